// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher
// Copies one sprite row from the sprite ROM into a line buffer when the VGA
// controller announces a new line. The copy can be mirrored horizontally.
// During active video it returns the buffered colour for the current draw_x
// one cycle later, and flags whether that pixel is opaque.
`timescale 1ns/1ps

module sprite_line_fetcher #(
    parameter int          SPR_W  = 20,
    parameter int          SPR_H  = 22,
    parameter int          ADDR_W = 9,
    parameter logic [11:0] TRANSP = 12'h808
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              line_start,
    input  logic [9:0]        next_y,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              flip,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [11:0]       rom_color,
    input  logic [9:0]        draw_x,
    output logic              busy,
    output logic              pixel_valid,
    output logic [11:0]       pixel_color
);

    localparam int               COL_W    = $clog2(SPR_W);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(SPR_W - 1);
    localparam logic [10:0]      SPR_W11  = 11'(SPR_W);
    localparam logic [10:0]      SPR_H11  = 11'(SPR_H);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        FETCH = 1'b1
    } state_t;

    state_t            state, state_next;
    logic [COL_W-1:0]  col, col_next;
    logic [ADDR_W-1:0] addr_next;
    logic              row_hit, row_hit_next;
    logic [9:0]        x_lat;
    logic              flip_lat;

    logic [11:0]       line_buf [SPR_W];
    logic              buf_we;
    logic [COL_W-1:0]  buf_idx;

    logic [10:0]       dy;
    logic              row_in_range;
    logic [ADDR_W-1:0] row_base;

    logic [10:0]       dx;
    logic              hit;
    logic [COL_W-1:0]  rd_idx;
    logic [11:0]       rd_color;

    assign busy = (state == FETCH);

    // Row selection: which sprite row (if any) lands on the announced line.
    always_comb begin
        dy           = {1'b0, next_y} - {1'b0, sprite_y};
        row_in_range = (next_y >= sprite_y) && (dy < SPR_H11);
        row_base     = ADDR_W'(dy * SPR_W11);
    end

    // Next-state logic for the fetch walk and its datapath controls.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a signal unassigned and no latch is inferred.
        state_next   = state;
        col_next     = col;
        addr_next    = rom_addr;
        row_hit_next = row_hit;
        buf_we       = 1'b0;
        buf_idx      = flip_lat ? (LAST_COL - col) : col;

        if (line_start) begin
            // A new line always invalidates the old row, even mid-fetch.
            row_hit_next = 1'b0;
            if (row_in_range) begin
                state_next = FETCH;
                col_next   = '0;
                addr_next  = row_base;
            end else begin
                state_next = IDLE;
            end
        end else if (state == FETCH) begin
            buf_we = 1'b1;
            if (col == LAST_COL) begin
                state_next   = IDLE;
                row_hit_next = 1'b1;
            end else begin
                col_next  = col + 1'b1;
                addr_next = rom_addr + 1'b1;
            end
        end
    end

    // FSM state register.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the values from before this edge.
            state <= state_next;
        end
    end

    // Fetch datapath registers: column, ROM address, row-valid flag, latched sprite attributes.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            col      <= '0;
            rom_addr <= '0;
            row_hit  <= 1'b0;
            x_lat    <= '0;
            flip_lat <= 1'b0;
        end else begin
            col      <= col_next;
            rom_addr <= addr_next;
            row_hit  <= row_hit_next;
            if (line_start) begin
                x_lat    <= sprite_x;
                flip_lat <= flip;
            end
        end
    end

    // Line buffer write; mirrored placement is folded into buf_idx.
    always_ff @(posedge Clk) begin
        // NOTE: the buffer has no reset; row_hit=0 after reset masks its
        // contents, and leaving it unreset lets it map onto plain RAM.
        if (buf_we) begin
            line_buf[buf_idx] <= rom_color;
        end
    end

    // Pixel lookup for the current draw_x.
    always_comb begin
        dx       = {1'b0, draw_x} - {1'b0, x_lat};
        hit      = row_hit && !busy && (draw_x >= x_lat) && (dx < SPR_W11);
        rd_idx   = hit ? dx[COL_W-1:0] : '0;
        rd_color = line_buf[rd_idx];
    end

    // Registered pixel output; transparent or off-sprite pixels read as black/invalid.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            pixel_valid <= 1'b0;
            pixel_color <= 12'h000;
        end else begin
            if (hit && (rd_color != TRANSP)) begin
                pixel_valid <= 1'b1;
                pixel_color <= rd_color;
            end else begin
                pixel_valid <= 1'b0;
                pixel_color <= 12'h000;
            end
        end
    end

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// tb_sprite_line_fetcher
// Directed bench: a table of row fetches (normal, mirrored, out-of-range, edge
// positions) plus hand-written sequences for reset mid-fetch and restart mid-fetch.
`timescale 1ns/1ps

module tb_sprite_line_fetcher;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic        line_start;
    logic [9:0]  next_y;
    logic [9:0]  sprite_x;
    logic [9:0]  sprite_y;
    logic        flip;
    logic [8:0]  rom_addr;
    logic [11:0] rom_color;
    logic [9:0]  draw_x;
    logic        busy;
    logic        pixel_valid;
    logic [11:0] pixel_color;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    sprite_line_fetcher dut (
        .Clk         (Clk),
        .Reset_n     (Reset_n),
        .line_start  (line_start),
        .next_y      (next_y),
        .sprite_x    (sprite_x),
        .sprite_y    (sprite_y),
        .flip        (flip),
        .rom_addr    (rom_addr),
        .rom_color   (rom_color),
        .draw_x      (draw_x),
        .busy        (busy),
        .pixel_valid (pixel_valid),
        .pixel_color (pixel_color)
    );

    // Model ROM: columns 5 and 13 of every row are transparent; every other
    // entry encodes its own address, so row and column are both visible.
    function automatic logic [11:0] rom_fn(input logic [8:0] a);
        if ((a % 20) == 5 || (a % 20) == 13) return 12'h808;
        return {a, 3'b001};
    endfunction

    assign rom_color = rom_fn(rom_addr);

    typedef struct {
        int   sy;
        int   ny;
        int   sx;
        logic fl;
        logic fetch;
        int   base;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Called at a negedge; returns at the negedge right after the line_start edge.
    task automatic start_line(input int ny, input int sy, input int sx, input logic fl);
        next_y     = 10'(ny);
        sprite_y   = 10'(sy);
        sprite_x   = 10'(sx);
        flip       = fl;
        draw_x     = 10'd1023;
        line_start = 1'b1;
        @(negedge Clk);
        line_start = 1'b0;
    endtask

    // Follows a fetch cycle by cycle: busy, address stepping, no pixels shown.
    task automatic watch_fetch(input int base, input int sx);
        for (int i = 0; i < 20; i++) begin
            check("fetch_busy", busy, 1);
            check("fetch_addr", rom_addr, base + i);
            check("fetch_no_pixel", pixel_valid, 0);
            draw_x = 10'(sx);
            @(negedge Clk);
        end
        check("fetch_busy_end", busy, 0);
        check("fetch_addr_hold", rom_addr, base + 19);
        draw_x = 10'd1023;
    endtask

    // Watches 20 cycles with no fetch expected.
    task automatic watch_idle();
        for (int i = 0; i < 20; i++) begin
            check("idle_busy", busy, 0);
            @(negedge Clk);
        end
    endtask

    // Sweeps draw_x around the sprite; each pixel is checked one cycle later.
    task automatic sweep(input int sx, input int row, input logic fl, input logic row_ok);
        int          k;
        logic        ev;
        logic [11:0] c;
        logic [11:0] ec;
        for (int d = sx - 10; d < sx + 30; d++) begin
            if (d >= 0) begin
                draw_x = 10'(d);
                @(negedge Clk);
                k  = d - sx;
                ev = 1'b0;
                c  = 12'h000;
                if (row_ok && k >= 0 && k < 20) begin
                    c  = rom_fn(9'(row * 20 + (fl ? 19 - k : k)));
                    ev = (c != 12'h808);
                end
                ec = ev ? c : 12'h000;
                check("pixel_valid", pixel_valid, ev);
                check("pixel_color", pixel_color, ec);
            end
        end
        draw_x = 10'd1023;
        @(negedge Clk);
    endtask

    initial begin
        vec_t v;

        vecs[0] = '{sy: 100, ny: 103, sx: 200, fl: 1'b0, fetch: 1'b1, base: 60};
        vecs[1] = '{sy: 100, ny: 103, sx: 200, fl: 1'b1, fetch: 1'b1, base: 60};
        vecs[2] = '{sy: 100, ny: 99,  sx: 200, fl: 1'b0, fetch: 1'b0, base: 0};
        vecs[3] = '{sy: 100, ny: 122, sx: 200, fl: 1'b0, fetch: 1'b0, base: 0};
        vecs[4] = '{sy: 100, ny: 121, sx: 5,   fl: 1'b1, fetch: 1'b1, base: 420};
        vecs[5] = '{sy: 0,   ny: 0,   sx: 620, fl: 1'b0, fetch: 1'b1, base: 0};

        Reset_n    = 1'b0;
        line_start = 1'b0;
        next_y     = '0;
        sprite_x   = '0;
        sprite_y   = '0;
        flip       = 1'b0;
        draw_x     = 10'd1023;

        #12;
        check("reset_busy", busy, 0);
        check("reset_valid", pixel_valid, 0);
        check("reset_color", pixel_color, 0);
        check("reset_addr", rom_addr, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);

        // Table-driven row fetches.
        for (int i = 0; i < 6; i++) begin
            v = vecs[i];
            start_line(v.ny, v.sy, v.sx, v.fl);
            if (v.fetch) watch_fetch(v.base, v.sx);
            else         watch_idle();
            sweep(v.sx, v.base / 20, v.fl, v.fetch);
        end

        // Valid row on screen, then reset asserted in the middle of a new fetch.
        start_line(103, 100, 200, 1'b0);
        watch_fetch(60, 200);
        start_line(103, 100, 200, 1'b0);
        repeat (7) @(negedge Clk);
        check("pre_reset_busy", busy, 1);
        check("pre_reset_addr", rom_addr, 67);
        #2;
        Reset_n = 1'b0;
        #1;
        check("async_reset_busy", busy, 0);
        check("async_reset_valid", pixel_valid, 0);
        check("async_reset_addr", rom_addr, 0);
        @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        sweep(200, 3, 1'b0, 1'b0);

        // Restart at col=10 with a different row; only new-row data may appear.
        start_line(103, 100, 200, 1'b0);
        repeat (10) @(negedge Clk);
        check("restart_mid_addr", rom_addr, 70);
        start_line(110, 100, 200, 1'b0);
        watch_fetch(200, 200);
        sweep(200, 10, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
